// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM capture block and the PWM generator.
// The glitch filter is enabled by defining PWM_CAPTURE_GLITCH_FILTER_EN.
package pwm_pkg;

   typedef enum logic [1:0] {
      WAIT_RISE = 2'd0,
      MEAS_HIGH = 2'd1,
      MEAS_LOW  = 2'd2
   } pwm_state_e;

   localparam int CNT_W_DEF       = 20;
   localparam int TIMEOUT_CYC_DEF = 100000;
   localparam int FILT_LEN_DEF    = 4;
   localparam int CLK_HZ          = 50_000_000;

endpackage

// File: rtl/pwm_in_sync.sv
// Synchronizes the PWM pin, optionally debounces it (PWM_CAPTURE_GLITCH_FILTER_EN),
// and produces the clean level plus single-cycle rise/fall strobes.
module pwm_in_sync
   import pwm_pkg::*;
#(
   parameter int FILT_LEN = FILT_LEN_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic pwm_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic sync_1;
   logic sync_2;
   logic lvl;
   logic lvl_q;

   if (FILT_LEN < 1) begin : g_bad_filt_len
      $error("FILT_LEN must be at least 1");
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= pwm_in;
         sync_2 <= sync_1;
      end
   end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   localparam int FC_W = $clog2(FILT_LEN + 1);

   logic            filt;
   logic [FC_W-1:0] filt_cnt;

   // filt only follows sync_2 after FILT_LEN consecutive samples at the new level
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         filt     <= 1'b0;
         filt_cnt <= '0;
      end else if (sync_2 == filt) begin
         filt_cnt <= '0;
      end else if (filt_cnt == FC_W'(FILT_LEN - 1)) begin
         filt     <= sync_2;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + 1'b1;
      end
   end

   assign lvl = filt;
`else
   assign lvl = sync_2;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lvl_q <= 1'b0;
      end else begin
         lvl_q <= lvl;
      end
   end

   assign level = lvl;
   assign rise  = lvl & ~lvl_q;
   assign fall  = ~lvl & lvl_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM high time and period in clk cycles and publishes one result per period;
// flags stuck lines. Optional input glitch filter: PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int FILT_LEN    = FILT_LEN_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pwm_in,
   input  logic             meas_ready,
   output logic             meas_valid,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] period_cnt,
   output logic             overrun,
   output logic             stuck_high,
   output logic             stuck_low,
   output pwm_state_e       state_dbg
);

   if (TIMEOUT_CYC < 1 || longint'(TIMEOUT_CYC) >= (longint'(1) << CNT_W)) begin : g_bad_timeout
      $error("TIMEOUT_CYC must lie in 1 .. 2**CNT_W-1");
   end

   logic             level;
   logic             rise;
   logic             fall;
   logic             edge_seen;
   logic             timeout;
   logic             publish;
   logic             xfer;
   pwm_state_e       state;
   logic [CNT_W-1:0] high_acc;
   logic [CNT_W-1:0] per_acc;
   logic [CNT_W-1:0] run_cnt;

   pwm_in_sync #(.FILT_LEN(FILT_LEN)) u_sync (
      .clk    (clk),
      .reset  (reset),
      .pwm_in (pwm_in),
      .level  (level),
      .rise   (rise),
      .fall   (fall)
   );

   assign edge_seen = rise | fall;
   assign timeout   = !edge_seen && (run_cnt == CNT_W'(TIMEOUT_CYC - 1));
   assign publish   = (state == MEAS_LOW) && rise;
   assign xfer      = meas_valid && meas_ready;
   assign state_dbg = state;

   // Cycles since the last edge; parks one past the timeout so the flag fires once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_cnt <= '0;
      end else if (edge_seen) begin
         run_cnt <= '0;
      end else if (run_cnt != CNT_W'(TIMEOUT_CYC)) begin
         run_cnt <= run_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= WAIT_RISE;
         high_acc   <= '0;
         per_acc    <= '0;
         stuck_high <= 1'b0;
         stuck_low  <= 1'b0;
      end else begin
         if (edge_seen) begin
            stuck_high <= 1'b0;
            stuck_low  <= 1'b0;
         end else if (timeout) begin
            stuck_high <= level;
            stuck_low  <= ~level;
         end

         if (timeout) begin
            state <= WAIT_RISE;
         end else begin
            case (state)
               WAIT_RISE: begin
                  if (rise) begin
                     high_acc <= CNT_W'(1);
                     per_acc  <= CNT_W'(1);
                     state    <= MEAS_HIGH;
                  end
               end
               MEAS_HIGH: begin
                  per_acc <= (per_acc == '1) ? per_acc : per_acc + 1'b1;
                  if (fall) begin
                     state <= MEAS_LOW;
                  end else begin
                     high_acc <= (high_acc == '1) ? high_acc : high_acc + 1'b1;
                  end
               end
               MEAS_LOW: begin
                  if (rise) begin
                     high_acc <= CNT_W'(1);
                     per_acc  <= CNT_W'(1);
                     state    <= MEAS_HIGH;
                  end else begin
                     per_acc <= (per_acc == '1) ? per_acc : per_acc + 1'b1;
                  end
               end
               default: state <= WAIT_RISE;
            endcase
         end
      end
   end

   // meas_valid/meas_ready: a transfer happens on a rising edge where both are 1; the
   // data holds while valid && !ready, and valid only falls after a transfer with no
   // publish in that cycle. A publish over unaccepted data overwrites it and sets overrun.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meas_valid <= 1'b0;
         high_cnt   <= '0;
         period_cnt <= '0;
         overrun    <= 1'b0;
      end else if (publish) begin
         meas_valid <= 1'b1;
         high_cnt   <= high_acc;
         period_cnt <= per_acc;
         if (meas_valid && !meas_ready) begin
            overrun <= 1'b1;
         end
      end else if (xfer) begin
         meas_valid <= 1'b0;
         overrun    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with shortened counter width and timeout.
// Also builds with PWM_CAPTURE_GLITCH_FILTER_EN defined.
module tb_pwm_capture;
   import pwm_pkg::*;

   localparam int CW      = 12;
   localparam int TO      = 200;
   localparam int FL      = 4;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   localparam int EDGE_LAT = 3 + FL;
`else
   localparam int EDGE_LAT = 3;
`endif

   logic          clk;
   logic          reset;
   logic          pwm_in;
   logic          meas_ready;
   logic          meas_valid;
   logic [CW-1:0] high_cnt;
   logic [CW-1:0] period_cnt;
   logic          overrun;
   logic          stuck_high;
   logic          stuck_low;
   pwm_state_e    state_dbg;

   logic [2*CW-1:0] exp_q[$];
   logic [2*CW-1:0] mon_e;
   int n_vec    = 0;
   int n_err    = 0;
   int xfer_cnt = 0;
   int xfer_ref;

   pwm_capture #(.CNT_W(CW), .TIMEOUT_CYC(TO), .FILT_LEN(FL)) dut (
      .clk        (clk),
      .reset      (reset),
      .pwm_in     (pwm_in),
      .meas_ready (meas_ready),
      .meas_valid (meas_valid),
      .high_cnt   (high_cnt),
      .period_cnt (period_cnt),
      .overrun    (overrun),
      .stuck_high (stuck_high),
      .stuck_low  (stuck_low),
      .state_dbg  (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      pwm_in     = 1'b0;
      meas_ready = 1'b0;
      reset      = 1'b0;
      exp_q.delete();
      wait_cyc(3);
      reset = 1'b1;
      wait_cyc(3);
   endtask

   task automatic pwm_periods(input int h, input int l, input int n);
      for (int i = 0; i < n; i++) begin
         pwm_in = 1'b1;
         wait_cyc(h);
         pwm_in = 1'b0;
         wait_cyc(l);
      end
   endtask

   task automatic push_exp(input int h, input int p);
      exp_q.push_back({CW'(h), CW'(p)});
   endtask

   // scoreboard: every accepted measurement must match the head of exp_q
   always @(negedge clk) begin
      if (reset && meas_valid && meas_ready) begin
         xfer_cnt++;
         check_val("xfer_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check_val("meas_high", 32'(high_cnt), 32'(mon_e[2*CW-1:CW]));
            check_val("meas_period", 32'(period_cnt), 32'(mon_e[CW-1:0]));
         end
      end
   end

   initial begin
      reset      = 1'b0;
      pwm_in     = 1'b0;
      meas_ready = 1'b0;
      wait_cyc(3);
      check_val("rst_valid", 32'(meas_valid), 32'd0);
      check_val("rst_high", 32'(high_cnt), 32'd0);
      check_val("rst_period", 32'(period_cnt), 32'd0);
      check_val("rst_overrun", 32'(overrun), 32'd0);
      check_val("rst_stuck_h", 32'(stuck_high), 32'd0);
      check_val("rst_stuck_l", 32'(stuck_low), 32'd0);
      check_val("rst_state", 32'(state_dbg), 32'(WAIT_RISE));

      // 25% duty, always ready
      do_reset();
      meas_ready = 1'b1;
      xfer_ref = xfer_cnt;
      for (int i = 0; i < 4; i++) push_exp(25, 100);
      pwm_periods(25, 75, 4);
      pwm_in = 1'b1;
      wait_cyc(10);
      check_val("t1_xfers", 32'(xfer_cnt - xfer_ref), 32'd4);
      check_val("t1_drained", 32'(exp_q.size()), 32'd0);
      check_val("t1_overrun", 32'(overrun), 32'd0);

      // 70% duty
      do_reset();
      meas_ready = 1'b1;
      xfer_ref = xfer_cnt;
      push_exp(70, 100);
      push_exp(70, 100);
      pwm_periods(70, 30, 2);
      pwm_in = 1'b1;
      wait_cyc(10);
      check_val("t1b_xfers", 32'(xfer_cnt - xfer_ref), 32'd2);

      // consumer stalled for three publishes, then accepts once
      do_reset();
      xfer_ref = xfer_cnt;
      pwm_periods(20, 80, 1);
      pwm_periods(30, 70, 1);
      pwm_periods(40, 60, 1);
      pwm_in = 1'b1;
      wait_cyc(10);
      check_val("t2_valid", 32'(meas_valid), 32'd1);
      check_val("t2_high", 32'(high_cnt), 32'd40);
      check_val("t2_period", 32'(period_cnt), 32'd100);
      check_val("t2_overrun_set", 32'(overrun), 32'd1);
      push_exp(40, 100);
      meas_ready = 1'b1;
      wait_cyc(1);
      meas_ready = 1'b0;
      wait_cyc(2);
      check_val("t2_overrun_clr", 32'(overrun), 32'd0);
      check_val("t2_valid_drop", 32'(meas_valid), 32'd0);
      check_val("t2_xfers", 32'(xfer_cnt - xfer_ref), 32'd1);

      // stuck low after reset, then stuck high, then recovery at 50% duty
      do_reset();
      wait_cyc(TO - 4);
      check_val("t3_stuck_l_early", 32'(stuck_low), 32'd0);
      wait_cyc(1);
      check_val("t3_stuck_l", 32'(stuck_low), 32'd1);
      pwm_in = 1'b1;
      wait_cyc(EDGE_LAT);
      check_val("t3_stuck_l_clr", 32'(stuck_low), 32'd0);
      check_val("t3_state_high", 32'(state_dbg), 32'(MEAS_HIGH));
      wait_cyc(TO - 1);
      check_val("t3_stuck_h_early", 32'(stuck_high), 32'd0);
      wait_cyc(1);
      check_val("t3_stuck_h", 32'(stuck_high), 32'd1);
      check_val("t3_state_wait", 32'(state_dbg), 32'(WAIT_RISE));
      wait_cyc(50);
      check_val("t3_stuck_h_hold", 32'(stuck_high), 32'd1);
      check_val("t3_no_valid", 32'(meas_valid), 32'd0);
      pwm_in = 1'b0;
      wait_cyc(EDGE_LAT - 1);
      check_val("t3_stuck_h_pre", 32'(stuck_high), 32'd1);
      wait_cyc(1);
      check_val("t3_stuck_h_clr", 32'(stuck_high), 32'd0);
      meas_ready = 1'b1;
      xfer_ref = xfer_cnt;
      push_exp(25, 50);
      push_exp(25, 50);
      pwm_periods(25, 25, 2);
      pwm_in = 1'b1;
      wait_cyc(10);
      check_val("t3_xfers", 32'(xfer_cnt - xfer_ref), 32'd2);

      // async reset in MEAS_LOW with a pending measurement
      do_reset();
      pwm_periods(30, 70, 1);
      pwm_in = 1'b1;
      wait_cyc(30);
      pwm_in = 1'b0;
      wait_cyc(20);
      check_val("t4_valid_pre", 32'(meas_valid), 32'd1);
      check_val("t4_state_low", 32'(state_dbg), 32'(MEAS_LOW));
      reset = 1'b0;
      #1;
      check_val("t4_valid_rst", 32'(meas_valid), 32'd0);
      check_val("t4_high_rst", 32'(high_cnt), 32'd0);
      check_val("t4_period_rst", 32'(period_cnt), 32'd0);
      check_val("t4_state_rst", 32'(state_dbg), 32'(WAIT_RISE));
      wait_cyc(10);
      reset = 1'b1;
      wait_cyc(3);
      meas_ready = 1'b1;
      xfer_ref = xfer_cnt;
      push_exp(30, 100);
      pwm_periods(30, 70, 1);
      check_val("t4_no_early_pub", 32'(xfer_cnt - xfer_ref), 32'd0);
      pwm_in = 1'b1;
      wait_cyc(10);
      check_val("t4_xfers", 32'(xfer_cnt - xfer_ref), 32'd1);

      // publish in the same cycle as accept while overrun is set
      do_reset();
      pwm_periods(20, 80, 1);
      pwm_periods(35, 65, 1);
      pwm_periods(45, 55, 1);
      check_val("t5_overrun_pre", 32'(overrun), 32'd1);
      push_exp(35, 100);
      pwm_in = 1'b1;
      wait_cyc(EDGE_LAT - 1);
      meas_ready = 1'b1;
      wait_cyc(1);
      meas_ready = 1'b0;
      wait_cyc(3);
      check_val("t5_valid_kept", 32'(meas_valid), 32'd1);
      check_val("t5_high_new", 32'(high_cnt), 32'd45);
      check_val("t5_period_new", 32'(period_cnt), 32'd100);
      check_val("t5_overrun_kept", 32'(overrun), 32'd1);
      push_exp(45, 100);
      meas_ready = 1'b1;
      wait_cyc(1);
      meas_ready = 1'b0;
      wait_cyc(2);
      check_val("t5_overrun_clr", 32'(overrun), 32'd0);
      check_val("t5_drained", 32'(exp_q.size()), 32'd0);

      // 2-cycle low glitch inside a high phase
      do_reset();
      meas_ready = 1'b1;
      xfer_ref = xfer_cnt;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      push_exp(25, 100);
`else
      push_exp(10, 12);
      push_exp(13, 88);
`endif
      pwm_in = 1'b1;
      wait_cyc(10);
      pwm_in = 1'b0;
      wait_cyc(2);
      pwm_in = 1'b1;
      wait_cyc(13);
      pwm_in = 1'b0;
      wait_cyc(75);
      pwm_in = 1'b1;
      wait_cyc(12);
      check_val("t6_drained", 32'(exp_q.size()), 32'd0);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      check_val("t6_xfers", 32'(xfer_cnt - xfer_ref), 32'd1);
`else
      check_val("t6_xfers", 32'(xfer_cnt - xfer_ref), 32'd2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
